// File: rtl/spi_master_ctrl_pkg.sv
// Shared SPI link definitions: command codes, frame size, master FSM states.
// The slave side imports the same package so both ends agree on the encoding.
package spi_defs;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT_TX,
    ST_WAIT_RD,
    ST_SHIFT_RD,
    ST_GAP
  } state_t;

  // Counter width large enough to hold the largest of the three cycle counts.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spi_master_ctrl_shift_reg.sv
// Parallel-load, MSB-first shift register with serial in/out and a shift counter.
// shift_data is the value the register takes on a shift, so callers can grab a full word on the last edge.
module spi_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic             serial_out,
  output logic [WIDTH-1:0] shift_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_next;
  logic [CNT_W-1:0] count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign shift_data[gi] = serial_in;
      end else begin : g_upper
        assign shift_data[gi] = data_reg[gi-1];
      end
      assign data_next[gi] = load ? load_data[gi] : (shift_en ? shift_data[gi] : data_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_reg  <= '0;
      count_reg <= '0;
    end else begin
      data_reg <= data_next;
      if (load) begin
        count_reg <= '0;
      end else if (shift_en) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  assign serial_out = data_reg[WIDTH-1];
  assign count      = count_reg;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI initiator: turns one {cmd, data} request into an 11-bit frame on SS_n/MOSI
// and, for read-data frames, collects the slave's reply byte from MISO.
module spi_master_ctrl
  import spi_defs::*;
#(
  parameter int ADDR_SIZE  = 8,
  parameter int MISO_DELAY = 2,  // must be >= 1
  parameter int IDLE_GAP   = 1   // must be >= 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_cmd,
  input  logic [ADDR_SIZE-1:0] req_data,
  output logic                 rsp_valid,
  output logic [ADDR_SIZE-1:0] rsp_data,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam int TX_BITS = ADDR_SIZE + 3;
  localparam int CNT_W   = cnt_width(TX_BITS, MISO_DELAY, ADDR_SIZE);

  state_t               state_reg;
  logic [1:0]           cmd_reg;
  logic [CNT_W-1:0]     cnt_reg;

  logic                 accept;
  logic                 tx_shift;
  logic                 rx_shift;
  logic                 tx_msb;
  logic                 tx_done;
  logic                 rx_last;
  logic [TX_BITS-1:0]   tx_word;
  logic [CNT_W-1:0]     tx_count;
  logic [CNT_W-1:0]     rx_count;
  logic [ADDR_SIZE-1:0] rx_shift_data;
  logic [TX_BITS-1:0]   tx_shift_data_unused;
  logic                 rx_msb_unused;

  assign accept   = req_valid && req_ready;
  // Bit 10 repeats cmd[1] so the slave can pick read/write from the first bit.
  assign tx_word  = {req_cmd[1], req_cmd, req_data};
  assign tx_shift = (state_reg == ST_LEAD) || ((state_reg == ST_SHIFT_TX) && !tx_done);
  assign rx_shift = (state_reg == ST_SHIFT_RD);
  assign tx_done  = (tx_count == CNT_W'(TX_BITS));
  assign rx_last  = (rx_count == CNT_W'(ADDR_SIZE - 1));

  spi_shift_reg #(.WIDTH(TX_BITS), .CNT_W(CNT_W)) u_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .load_data  (tx_word),
    .shift_en   (tx_shift),
    .serial_in  (1'b0),
    .serial_out (tx_msb),
    .shift_data (tx_shift_data_unused),
    .count      (tx_count)
  );

  spi_shift_reg #(.WIDTH(ADDR_SIZE), .CNT_W(CNT_W)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (accept),
    .load_data  ({ADDR_SIZE{1'b0}}),
    .shift_en   (rx_shift),
    .serial_in  (MISO),
    .serial_out (rx_msb_unused),
    .shift_data (rx_shift_data),
    .count      (rx_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cmd_reg   <= CMD_WR_ADDR;
      cnt_reg   <= '0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            cmd_reg   <= req_cmd;
            SS_n      <= 1'b0;
            MOSI      <= 1'b0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            state_reg <= ST_LEAD;
          end
        end
        ST_LEAD: begin
          MOSI      <= tx_msb;
          state_reg <= ST_SHIFT_TX;
        end
        ST_SHIFT_TX: begin
          if (tx_done) begin
            MOSI    <= 1'b0;
            cnt_reg <= '0;
            if (cmd_reg == CMD_RD_DATA) begin
              state_reg <= ST_WAIT_RD;
            end else begin
              SS_n      <= 1'b1;
              state_reg <= ST_GAP;
            end
          end else begin
            MOSI <= tx_msb;
          end
        end
        ST_WAIT_RD: begin
          // Slave and RAM turnaround before the reply's MSB is on MISO.
          if (cnt_reg == CNT_W'(MISO_DELAY - 1)) begin
            cnt_reg   <= '0;
            state_reg <= ST_SHIFT_RD;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_SHIFT_RD: begin
          if (rx_last) begin
            SS_n      <= 1'b1;
            rsp_data  <= rx_shift_data;
            rsp_valid <= 1'b1;
            state_reg <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (cnt_reg == CNT_W'(IDLE_GAP - 1)) begin
            cnt_reg   <= '0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          SS_n      <= 1'b1;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural SPI slave + 256x8 RAM model.
module tb_spi_master_ctrl;
  import spi_defs::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_cmd;
  logic [7:0] req_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  spi_master_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  always #1 clk = ~clk;

  // Slave model: counts posedges with SS_n low, shifts in 11 MOSI bits, serves replies.
  logic [7:0]  mem [256];
  logic [7:0]  wr_addr_q, rd_addr_q, rd_byte;
  logic [9:0]  s_frame;
  logic [10:0] s_word;
  int          s_cnt = 0;
  logic        force_en = 1'b0;
  logic [7:0]  force_byte = 8'h00;
  logic        noise_en = 1'b0;

  always @(posedge clk) begin
    if (SS_n) begin
      s_cnt <= 0;
    end else begin
      s_cnt <= s_cnt + 1;
      if (s_cnt >= 1 && s_cnt <= 10) s_frame <= {s_frame[8:0], MOSI};
      if (s_cnt == 11) begin
        s_word = {s_frame, MOSI};
        case (s_word[9:8])
          2'b00: wr_addr_q <= s_word[7:0];
          2'b01: mem[wr_addr_q] <= s_word[7:0];
          2'b10: rd_addr_q <= s_word[7:0];
          default: rd_byte <= force_en ? force_byte : mem[rd_addr_q];
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (!SS_n && s_cnt >= 14 && s_cnt <= 21) MISO = rd_byte[21 - s_cnt];
    else MISO = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(req_ready), 1);
  endtask

  int         f_ss_low, f_rsp_cnt, f_rsp_cyc, f_busy_cyc, f_rise_cyc;
  logic [11:0] f_mosi;
  logic [7:0]  f_rsp_data;

  // Issue one request and record the frame cycle by cycle (cycle 0 = after accept edge).
  task automatic run_frame(input logic [1:0] cmd, input logic [7:0] data);
    wait_ready();
    req_cmd = cmd; req_data = data; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    f_ss_low = 0; f_rsp_cnt = 0; f_rsp_cyc = -1; f_busy_cyc = -1; f_rise_cyc = -1;
    f_mosi = '0; f_rsp_data = '0;
    for (int i = 0; i < 80; i++) begin
      if (i > 0) @(negedge clk);
      if (!SS_n) f_ss_low++;
      else if (f_rise_cyc < 0) f_rise_cyc = i;
      if (i < 12) f_mosi[11-i] = MOSI;
      if (rsp_valid) begin f_rsp_cnt++; f_rsp_data = rsp_data; f_rsp_cyc = i; end
      if (!busy) begin f_busy_cyc = i; break; end
    end
    check("frame_done_in_budget", 32'(f_busy_cyc >= 0), 1);
  endtask

  initial begin
    int rise, fall, rdy_early, rdy13, pulses, n;
    rst_n = 1'b0; req_valid = 1'b0; req_cmd = 2'b00; req_data = 8'h00;
    repeat (15) @(negedge clk);
    check("rst_ss_n", 32'(SS_n), 1);
    check("rst_mosi", 32'(MOSI), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_req_ready", 32'(req_ready), 1);

    // T1 wr-addr FF
    run_frame(CMD_WR_ADDR, 8'hFF);
    check("t1_mosi", 32'(f_mosi), 32'h0FF);
    check("t1_ss_low", f_ss_low, 12);
    check("t1_ss_rise", f_rise_cyc, 12);
    check("t1_no_rsp", f_rsp_cnt, 0);
    check("t1_busy_len", f_busy_cyc, 13);
    $display("T1 wr-addr FF: mosi=%h ss_low=%0d", f_mosi, f_ss_low);

    // T2 wr-data 55
    run_frame(CMD_WR_DATA, 8'h55);
    check("t2_mosi", 32'(f_mosi), 32'h155);
    check("t2_ss_low", f_ss_low, 12);
    check("t2_ram_ff", 32'(mem[8'hFF]), 32'h55);
    $display("T2 wr-data 55: mosi=%h ram[FF]=%h", f_mosi, mem[8'hFF]);

    // T3 read back address FF
    run_frame(CMD_RD_ADDR, 8'hFF);
    check("t3a_mosi", 32'(f_mosi), 32'h6FF);
    check("t3a_no_rsp", f_rsp_cnt, 0);
    run_frame(CMD_RD_DATA, 8'h00);
    check("t3_mosi", 32'(f_mosi), 32'h700);
    check("t3_ss_low", f_ss_low, 22);
    check("t3_rsp_cnt", f_rsp_cnt, 1);
    check("t3_rsp_data", 32'(f_rsp_data), 32'h55);
    check("t3_rsp_cyc", f_rsp_cyc, 22);
    check("t3_busy_len", f_busy_cyc, 23);
    $display("T3 read FF: rsp=%h pulses=%0d ss_low=%0d", f_rsp_data, f_rsp_cnt, f_ss_low);

    // T4 request held while busy: wr-addr 12, then wr-data 34 waiting
    wait_ready();
    req_cmd = CMD_WR_ADDR; req_data = 8'h12; req_valid = 1'b1;
    @(negedge clk);
    req_cmd = CMD_WR_DATA; req_data = 8'h34;
    rise = -1; fall = -1; rdy_early = 0; rdy13 = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (req_ready && i < 13) rdy_early++;
      if (i == 13) rdy13 = 32'(req_ready);
      if (SS_n && rise < 0) rise = i;
      if (!SS_n && rise >= 0 && fall < 0) begin fall = i; req_valid = 1'b0; break; end
    end
    req_valid = 1'b0;
    check("t4_ready_low_while_busy", rdy_early, 0);
    check("t4_ready_at_idle", rdy13, 1);
    check("t4_ss_rise", rise, 12);
    check("t4_restart_gap", fall - rise, 2);
    n = 0;
    while (busy && n < 60) begin @(negedge clk); n++; end
    check("t4_second_done", 32'(busy), 0);
    check("t4_ram_12", 32'(mem[8'h12]), 32'h34);
    check("t4_rsp_data_held", 32'(rsp_data), 32'h55);
    $display("T4 busy hold: rise=%0d fall=%0d ram[12]=%h", rise, fall, mem[8'h12]);

    // T5 reset in the middle of a rd-data frame
    wait_ready();
    req_cmd = CMD_RD_DATA; req_data = 8'h00; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_ss_n", 32'(SS_n), 1);
    check("t5_mosi", 32'(MOSI), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_req_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    check("t5_no_rsp", pulses, 0);
    run_frame(CMD_WR_ADDR, 8'hC3);
    check("t5_next_mosi", 32'(f_mosi), 32'h0C3);
    check("t5_next_ss_low", f_ss_low, 12);
    $display("T5 reset mid-frame: pulses=%0d next mosi=%h", pulses, f_mosi);

    // T6 forced reply bytes with MISO noise outside the read window
    noise_en = 1'b1;
    force_en = 1'b1; force_byte = 8'hA5;
    run_frame(CMD_RD_DATA, 8'h00);
    check("t6_rsp_a5", 32'(f_rsp_data), 32'hA5);
    check("t6_rsp_a5_cnt", f_rsp_cnt, 1);
    repeat (7) @(negedge clk);
    check("t6_rsp_held", 32'(rsp_data), 32'hA5);
    force_byte = 8'h00;
    run_frame(CMD_RD_DATA, 8'hFF);
    check("t6_rsp_00", 32'(f_rsp_data), 32'h00);
    check("t6_mosi_ff", 32'(f_mosi), 32'h7FF);
    force_en = 1'b0;
    run_frame(CMD_RD_ADDR, 8'h12);
    run_frame(CMD_RD_DATA, 8'h5A);
    check("t6_mosi_5a", 32'(f_mosi), 32'h75A);
    check("t6_rsp_34", 32'(f_rsp_data), 32'h34);
    $display("T6 miso pattern: last rsp=%h", f_rsp_data);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
